// File: rtl/uart_tx_frame_if.sv
// Byte-in / serial-out bundle for the UART transmit framer.
// The master offers bytes; the slave (the framer) drives the line and status.
interface uart_tx_frame_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       serial_out;
   logic       tx_busy;
   logic       tx_done;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  serial_out,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output serial_out,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB first, parity, stop; CLKS_PER_BIT clocks per bit.
// State encoding matches the Rx FSM so a loopback receiver decodes frames directly.
module uart_tx_frame #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   uart_tx_frame_if.slave  tx_io
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StStart  = 4'd1,
      StD0     = 4'd2,
      StD1     = 4'd3,
      StD2     = 4'd4,
      StD3     = 4'd5,
      StD4     = 4'd6,
      StD5     = 4'd7,
      StD6     = 4'd8,
      StD7     = 4'd9,
      StParity = 4'd10,
      StStop   = 4'd11
   } state_t;

   state_t          state_q;
   logic [CntW-1:0] cnt_q;
   logic [7:0]      shift_q;
   logic            parity_q;
   logic            serial_q;
   logic            done_q;

   // serial_q is loaded with the level of the state being entered, so the line
   // changes on the same edge as the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         serial_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               serial_q <= 1'b1;
               cnt_q    <= '0;
               if (tx_io.tx_valid) begin
                  shift_q  <= tx_io.tx_data;
                  parity_q <= ^tx_io.tx_data ^ PARITY_ODD;
                  state_q  <= StStart;
                  serial_q <= 1'b0;
               end
            end
            StStart, StD0, StD1, StD2, StD3, StD4, StD5, StD6, StD7, StParity, StStop: begin
               if (cnt_q == CntMax) begin
                  cnt_q <= '0;
                  case (state_q)
                     StStart: begin
                        state_q  <= StD0;
                        serial_q <= shift_q[0];
                     end
                     StD0, StD1, StD2, StD3, StD4, StD5, StD6: begin
                        state_q  <= state_t'(state_q + 4'd1);
                        shift_q  <= {1'b0, shift_q[7:1]};
                        serial_q <= shift_q[1];
                     end
                     StD7: begin
                        state_q  <= StParity;
                        serial_q <= parity_q;
                     end
                     StParity: begin
                        state_q  <= StStop;
                        serial_q <= 1'b1;
                     end
                     StStop: begin
                        state_q  <= StIdle;
                        serial_q <= 1'b1;
                        done_q   <= 1'b1;
                     end
                     default: begin
                        state_q  <= StIdle;
                        serial_q <= 1'b1;
                     end
                  endcase
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            // Encodings 12..15 are unreachable; recover to an idle line.
            default: begin
               state_q  <= StIdle;
               cnt_q    <= '0;
               serial_q <= 1'b1;
            end
         endcase
      end
   end

   assign tx_io.tx_ready   = (state_q == StIdle);
   assign tx_io.tx_busy    = (state_q != StIdle);
   assign tx_io.serial_out = serial_q;
   assign tx_io.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (CPB4 even, CPB4 odd, CPB2 even) checked
// cycle by cycle against a frame model built from the byte, parity rule and bit period.
module tb_uart_tx_frame;

   logic clk;
   logic rst;
   int   vectors;
   int   fails;

   logic [7:0] data_v  [3];
   logic       valid_v [3];
   logic       ser     [3];
   logic       rdy     [3];
   logic       busy    [3];
   logic       done    [3];

   uart_tx_frame_if u_if0 ();
   uart_tx_frame_if u_if1 ();
   uart_tx_frame_if u_if2 ();

   assign u_if0.tx_data = data_v[0];
   assign u_if1.tx_data = data_v[1];
   assign u_if2.tx_data = data_v[2];
   assign u_if0.tx_valid = valid_v[0];
   assign u_if1.tx_valid = valid_v[1];
   assign u_if2.tx_valid = valid_v[2];
   assign ser[0] = u_if0.serial_out;
   assign ser[1] = u_if1.serial_out;
   assign ser[2] = u_if2.serial_out;
   assign rdy[0] = u_if0.tx_ready;
   assign rdy[1] = u_if1.tx_ready;
   assign rdy[2] = u_if2.tx_ready;
   assign busy[0] = u_if0.tx_busy;
   assign busy[1] = u_if1.tx_busy;
   assign busy[2] = u_if2.tx_busy;
   assign done[0] = u_if0.tx_done;
   assign done[1] = u_if1.tx_done;
   assign done[2] = u_if2.tx_done;

   uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_dut0 (.clk(clk), .reset(rst), .tx_io(u_if0));
   uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_dut1 (.clk(clk), .reset(rst), .tx_io(u_if1));
   uart_tx_frame #(.CLKS_PER_BIT(2), .PARITY_ODD(1'b0)) u_dut2 (.clk(clk), .reset(rst), .tx_io(u_if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cpb_of(input int s);
      return (s == 2) ? 2 : 4;
   endfunction

   function automatic bit odd_of(input int s);
      return (s == 1);
   endfunction

   // Line levels of a whole frame, index 0 = start bit, 10 = stop bit.
   function automatic logic [10:0] frame_of(input logic [7:0] b, input bit odd);
      return {1'b1, (^b) ^ odd, b, 1'b0};
   endfunction

   task automatic chk1(input string tag, input logic got, input logic exp);
      vectors++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input int s, input string tag);
      chk1({tag, "_ser"}, ser[s], 1'b1);
      chk1({tag, "_rdy"}, rdy[s], 1'b1);
      chk1({tag, "_busy"}, busy[s], 1'b0);
      chk1({tag, "_done"}, done[s], 1'b0);
   endtask

   // Sends one byte on instance s. chained: byte already offered and accepted on the next edge.
   // hold_next: keep tx_valid high with nb so the next frame starts right after tx_done.
   // abort_at >= 0: pulse reset at that sample and abandon the frame.
   task automatic frame(input int s, input logic [7:0] b, input bit chained,
                        input bit hold_next, input logic [7:0] nb, input int abort_at);
      int          cpb;
      logic [10:0] fb;
      logic [7:0]  rx;
      cpb = cpb_of(s);
      fb  = frame_of(b, odd_of(s));
      rx  = '0;
      if (!chained) begin
         @(negedge clk);
         chk1("pre_rdy", rdy[s], 1'b1);
         data_v[s]  = b;
         valid_v[s] = 1'b1;
      end
      for (int e = 0; e <= 11 * cpb; e++) begin
         @(negedge clk);
         if (e < 11 * cpb) begin
            chk1("bit", ser[s], fb[e / cpb]);
            chk1("rdy_low", rdy[s], 1'b0);
            chk1("busy", busy[s], 1'b1);
            chk1("done_low", done[s], 1'b0);
            if (e >= cpb && e < 9 * cpb && (e % cpb) == cpb / 2) rx[e / cpb - 1] = ser[s];
         end else begin
            chk1("stop_ser", ser[s], 1'b1);
            chk1("done", done[s], 1'b1);
            chk1("rdy_back", rdy[s], 1'b1);
            chk8("rx_byte", rx, b);
         end
         if (e == 0) begin
            valid_v[s] = hold_next;
            data_v[s]  = hold_next ? nb : 8'($urandom);
         end
         if (e == 2 * cpb) begin
            valid_v[s] = 1'b1;
            data_v[s]  = ~b;
         end
         if (e == 2 * cpb + 1) begin
            valid_v[s] = hold_next;
            data_v[s]  = hold_next ? nb : 8'($urandom);
         end
         if (e == abort_at) begin
            rst = 1'b1;
            #1;
            chk1("rst_ser", ser[s], 1'b1);
            chk1("rst_rdy", rdy[s], 1'b1);
            chk1("rst_done", done[s], 1'b0);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 2 * cpb; k++) begin
               @(negedge clk);
               check_idle(s, "post_rst");
            end
            return;
         end
      end
      if (!hold_next) begin
         @(negedge clk);
         check_idle(s, "gap");
      end
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] nb;
      int         s;
      vectors = 0;
      fails   = 0;
      rst     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_v[i]  = '0;
         valid_v[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) check_idle(i, "reset");
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_idle(i, "after_reset");

      frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, -1);
      frame(1, 8'h00, 1'b0, 1'b0, 8'h00, -1);
      frame(0, 8'hFF, 1'b0, 1'b0, 8'h00, -1);
      frame(0, 8'h3C, 1'b0, 1'b1, 8'hC3, -1);
      frame(0, 8'hC3, 1'b1, 1'b0, 8'h00, -1);
      // Reset lands in D3 (bit index 4).
      frame(0, 8'h5A, 1'b0, 1'b0, 8'h00, 4 * 4 + 1);
      frame(0, 8'h55, 1'b0, 1'b0, 8'h00, -1);
      frame(2, 8'h81, 1'b0, 1'b0, 8'h00, -1);

      repeat (24) begin
         s  = int'($urandom_range(0, 2));
         b  = 8'($urandom);
         nb = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            frame(s, b, 1'b0, 1'b1, nb, -1);
            frame(s, nb, 1'b1, 1'b0, 8'h00, -1);
         end else begin
            frame(s, b, 1'b0, 1'b0, 8'h00, -1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmit framer: accepts one byte per valid/ready handshake and serialises it as one 8-E-1 frame, or 8-O-1 with `PARITY_ODD=1`. A frame is start bit, D0..D7 LSB first, parity bit, stop bit. Each bit is held for `CLKS_PER_BIT` clocks by an internal baud counter. The block is the transmit-side counterpart of the Rx FSM: its output drives the serial line that the Rx sampler and start detector consume. It uses the same 4-bit state encoding, so a loopback Rx decodes its frames directly.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clocks per serial bit; legal range 2..65535.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `tx_data`  in  8  byte to send; sampled only on the accept edge.
- `tx_valid`  in  1  byte offered.
- `tx_ready`  out  1  block is in IDLE and can accept a byte.
- `serial_out`  out  1  UART line; idles high.
- `tx_busy`  out  1  a frame is in progress (any non-IDLE state).
- `tx_done`  out  1  one-cycle pulse at the end of the stop bit.

## Operation
- States (4-bit):
  - IDLE=0, START=1, D0..D7=2..9, PARITY=10, STOP=11.
  - Encodings 12..15 are illegal; if entered, return to IDLE on the next edge with `serial_out`=1.
- Accept:
  - Occurs on an edge where `tx_valid && tx_ready`.
  - On that edge: shift register <= `tx_data`, parity register <= `^tx_data ^ PARITY_ODD`, baud counter <= 0, state <= START.
  - `tx_valid` while not ready is ignored; there is no queueing.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT`-1 in every non-IDLE state.
  - At terminal count: wraps to 0 and the state advances.
- Transitions at terminal count:
  - START -> D0.
  - Dn -> Dn+1, shifting the shift register right by 1.
  - D7 -> PARITY.
  - PARITY -> STOP.
  - STOP -> IDLE.
- `serial_out` is registered:
  - IDLE = 1.
  - START = 0.
  - Dn = shift register bit 0.
  - PARITY = parity register.
  - STOP = 1.
- `tx_ready` = (state==IDLE), combinational from the state register.
- `tx_busy` = !`tx_ready`.
- `tx_done` is registered: 1 in the cycle after the STOP terminal-count edge, otherwise 0.
- Reset (asserted at any time, including mid-frame):
  - Immediately forces state=IDLE, counter=0, `serial_out`=1, `tx_done`=0, shift and parity registers = 0.
  - A partial frame is abandoned; no completion pulse is generated.
- Reset values: `serial_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.

## Timing
- Accept edge at cycle T:
  - `serial_out` falls at T+1.
  - Each bit occupies exactly `CLKS_PER_BIT` cycles.
  - The stop bit is high during T+1+10·CPB .. T+11·CPB.
- Return to IDLE:
  - The STOP terminal edge is T+11·CPB; the state is IDLE after it.
  - `tx_ready`=1 and `tx_done`=1 in the same cycle, which begins at T+11·CPB.
- Back-to-back frames:
  - A byte accepted in that `tx_done` cycle starts its START bit one cycle later.
  - Minimum line-idle gap between frames is therefore 1 clock beyond the full stop bit.
  - Frame period is 11·CPB+1 clocks.
- Acceptance latency: 0 cycles from `tx_valid` when IDLE; `tx_ready` drops on the accept edge.
- `tx_data` may change freely after the accept edge without affecting the frame in flight.

## Test plan
- CPB=4, even parity, send 0xA5:
  - `serial_out` per 4-cycle bit = 0,1,0,1,0,0,1,0,1,0,1.
  - `tx_done` pulses once at T+44.
- CPB=4, odd parity, send 0x00: parity bit = 1. Even parity with 0xFF: parity bit = 0.
- `tx_valid` held high with 0x3C then 0xC3:
  - Exactly two frames, 45 cycles apart.
  - Line high for exactly 1 extra cycle between them.
  - Loopback Rx reports 0x3C then 0xC3.
- Toggle `tx_data` and pulse `tx_valid` mid-frame: transmitted bits unchanged; `tx_ready` stays 0 until `tx_done`.
- Assert `reset` for 1 cycle during D3:
  - `serial_out`=1 with no clock delay; state IDLE; no `tx_done` pulse.
  - Next byte 0x55 is sent correctly.
- CPB=2 minimum: send 0x81 -> 22-cycle frame, bits 0,1,0,0,0,0,0,0,1,0,1.
